// File: rtl/alu32.sv
// Registered 32-bit ALU: one-cycle latency, one op per cycle, never stalls (no backpressure).
// Define ALU_SAT_EN to make ADD/SUB clamp instead of wrap; carry still flags the clamp.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_code,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ready
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;

  op_t             op;
  logic [SW-1:0]   shamt;
  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  diff;
  logic [WIDTH:0]  shl_w;
  logic [WIDTH:0]  shr_w;
  logic [WIDTH-1:0] nxt_out;
  logic            nxt_carry;
  logic            nxt_ready;

  assign op    = op_t'(op_code);
  assign shamt = b[SW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  // One extra bit on each shift catches the last bit shifted out; shamt=0 yields 0.
  assign shl_w = {1'b0, a} << shamt;
  assign shr_w = {a, 1'b0} >> shamt;

  always_comb begin
    nxt_out   = out;
    nxt_carry = carry;
    nxt_ready = 1'b1;
    case (op)
      OP_NOP: nxt_ready = 1'b0;
      OP_ADD: begin
`ifdef ALU_SAT_EN
        nxt_out = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        nxt_out = sum[WIDTH-1:0];
`endif
        nxt_carry = sum[WIDTH];
      end
      OP_SUB: begin
`ifdef ALU_SAT_EN
        nxt_out = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
        nxt_out = diff[WIDTH-1:0];
`endif
        nxt_carry = diff[WIDTH];
      end
      OP_AND: begin
        nxt_out   = a & b;
        nxt_carry = 1'b0;
      end
      OP_OR: begin
        nxt_out   = a | b;
        nxt_carry = 1'b0;
      end
      OP_XOR: begin
        nxt_out   = a ^ b;
        nxt_carry = 1'b0;
      end
      OP_SHL: begin
        nxt_out   = shl_w[WIDTH-1:0];
        nxt_carry = shl_w[WIDTH];
      end
      OP_SHR: begin
        nxt_out   = shr_w[WIDTH:1];
        nxt_carry = shr_w[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out   <= '0;
      carry <= 1'b0;
      ready <= 1'b0;
    end else begin
      out   <= nxt_out;
      carry <= nxt_carry;
      ready <= nxt_ready;
    end
  end

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: driver queues hand-computed results, monitor checks after each edge.
module tb_alu32;

  logic        clk;
  logic        nrst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op_code;
  logic [31:0] out;
  logic        carry;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] out;
    logic        carry;
    logic        ready;
    logic [2:0]  op;
  } exp_t;

  exp_t exp_q[$];

  alu32 #(.WIDTH(32)) dut (
    .clk(clk), .nrst(nrst), .a(a), .b(b), .op_code(op_code),
    .out(out), .carry(carry), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got out=%h carry=%b ready=%b, expected out=%h carry=%b ready=%b",
               name, act[33:2], act[1], act[0], req[33:2], req[1], req[0]);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] e_out, input logic e_c, input logic e_r);
    exp_t e;
    @(negedge clk);
    op_code = op;
    a       = va;
    b       = vb;
    e.out = e_out; e.carry = e_c; e.ready = e_r; e.op = op;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d results never appeared, expected 0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every edge out of reset presents a result; compare it against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (nrst && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("op%0d", e.op), {out, carry, ready}, {e.out, e.carry, e.ready});
      end
    end
  end

  initial begin
    nrst = 1'b0; op_code = 3'b001; a = 32'd5; b = 32'd7;
    repeat (2) @(posedge clk);
    #1 check("reset_hold", {out, carry, ready}, 34'd0);

    @(negedge clk);
    nrst = 1'b1;
    exp_q.push_back('{out: 32'd12, carry: 1'b0, ready: 1'b1, op: 3'b001});

`ifdef ALU_SAT_EN
    issue(3'b001, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    issue(3'b010, 32'd3, 32'd5, 32'h0000_0000, 1'b1, 1'b1);
`else
    issue(3'b001, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b1);
    issue(3'b010, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b1);
`endif
    issue(3'b010, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
    issue(3'b001, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b1);
    issue(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b1);
    issue(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b1);
    issue(3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b1);
    issue(3'b110, 32'h8000_0001, 32'd1, 32'h0000_0002, 1'b1, 1'b1);
    issue(3'b111, 32'h8000_0001, 32'd1, 32'h4000_0000, 1'b1, 1'b1);
    issue(3'b110, 32'h8000_0001, 32'h20, 32'h8000_0001, 1'b0, 1'b1);
    issue(3'b111, 32'h8000_0001, 32'h20, 32'h8000_0001, 1'b0, 1'b1);
    issue(3'b110, 32'h0000_0003, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    issue(3'b111, 32'hC000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
    issue(3'b110, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 1'b1);
    issue(3'b001, 32'd2, 32'd2, 32'd4, 1'b0, 1'b1);
    issue(3'b000, 32'd9, 32'd9, 32'd4, 1'b0, 1'b0);
    issue(3'b000, 32'd1, 32'd1, 32'd4, 1'b0, 1'b0);
    drain();

    // Reset asserted between edges must clear outputs without a clock edge.
    @(posedge clk);
    #2;
    op_code = 3'b001; a = 32'd100; b = 32'd1;
    nrst = 1'b0;
    #1 check("async_reset", {out, carry, ready}, 34'd0);
    @(posedge clk);
    #1 check("reset_abort", {out, carry, ready}, 34'd0);

    @(negedge clk);
    nrst = 1'b1;
    exp_q.push_back('{out: 32'd101, carry: 1'b0, ready: 1'b1, op: 3'b001});
    issue(3'b010, 32'd10, 32'd4, 32'd6, 1'b0, 1'b1);
    issue(3'b000, 32'd0, 32'd0, 32'd6, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
